// File: rtl/adpll_loop_filter.sv
// adpll_loop_filter: PI loop filter turning bang-bang up/dn into a registered DCO control word
// Ports: clk, rst (async, active-high), up/dn (phase detector), pgm/pgm_value (preset load/hold),
//        ctrl_word (DCO control), lock (lock flag), state (0=HOLD, 1=ACQUIRE, 2=TRACK).
// Define ADPLL_LOCK_DETECT_EN to enable lock/run tracking and the TRACK gear; otherwise lock is 0
// and the filter stays in ACQUIRE gain.
module adpll_loop_filter #(
    parameter int CTRL_W       = 8,
    parameter int FRAC_W       = 4,
    parameter int DEFAULT_CTRL = 128,
    parameter int KP           = 4,
    parameter int KI_ACQ_SHIFT = 3,
    parameter int KI_TRK_SHIFT = 0,
    parameter int LOCK_CNT     = 16,
    parameter int RUN_MAX      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up,
    input  logic              dn,
    input  logic              pgm,
    input  logic [4:0]        pgm_value,
    output logic [CTRL_W-1:0] ctrl_word,
    output logic              lock,
    output logic [1:0]        state
);
    localparam int ACC_W = CTRL_W + FRAC_W;
    localparam logic [ACC_W-1:0]  ACC_RST  = ACC_W'(DEFAULT_CTRL << FRAC_W);
    localparam logic [ACC_W+1:0]  STEP_ACQ = (ACC_W+2)'(1 << KI_ACQ_SHIFT);
    localparam logic [ACC_W+1:0]  STEP_TRK = (ACC_W+2)'(1 << KI_TRK_SHIFT);
    localparam logic [CTRL_W+1:0] KP_W     = (CTRL_W+2)'(KP);
    typedef enum logic [1:0] {HOLD = 2'd0, ACQUIRE = 2'd1, TRACK = 2'd2} state_t;
    state_t st, st_n;
    logic pos, neg;
    logic [ACC_W+1:0] step, acc_sum;
    logic [ACC_W-1:0] acc, acc_n;
    logic [CTRL_W+1:0] ctrl_sum;
    logic [CTRL_W-1:0] ctrl_n;
    assign pos   = up & ~dn;
    assign neg   = dn & ~up;
    assign state = st;
    // Sums are two's complement with two guard bits: top bit set means negative,
    // next bit set means overflow past the unsigned range.
    always_comb begin
        step     = (st == TRACK) ? STEP_TRK : STEP_ACQ;
        acc_sum  = {2'b00, acc} + (pos ? step : neg ? -step : '0);
        acc_n    = acc_sum[ACC_W+1] ? '0 : acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        ctrl_sum = {2'b00, acc_n[ACC_W-1:FRAC_W]} + (pos ? KP_W : neg ? -KP_W : '0);
        ctrl_n   = ctrl_sum[CTRL_W+1] ? '0 : ctrl_sum[CTRL_W] ? '1 : ctrl_sum[CTRL_W-1:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= ACC_RST;
            ctrl_word <= CTRL_W'(DEFAULT_CTRL);
        end else if (pgm) begin
            acc       <= ACC_W'(pgm_value) << (CTRL_W - 5 + FRAC_W);
            ctrl_word <= CTRL_W'(pgm_value) << (CTRL_W - 5);
        end else if (st == HOLD) begin
            ctrl_word <= acc[ACC_W-1:FRAC_W];
        end else begin
            acc       <= acc_n;
            ctrl_word <= ctrl_n;
        end
    end
`ifdef ADPLL_LOCK_DETECT_EN
    localparam int LC_W = $clog2(LOCK_CNT + 1);
    localparam int RL_W = $clog2(RUN_MAX + 1);
    localparam logic [LC_W-1:0] LC_MAX = LC_W'(LOCK_CNT);
    localparam logic [RL_W-1:0] RL_MAX = RL_W'(RUN_MAX);
    logic [LC_W-1:0] lock_cnt, lc_n;
    logic [RL_W-1:0] run_len, rl_n;
    logic last_sign, same, run_hit;
    // Sign is kept as a sign bit: 1 for dn (negative error), 0 for up.
    always_comb begin
        same    = (pos | neg) & (neg == last_sign);
        lc_n    = same ? '0 : (lock_cnt == LC_MAX) ? lock_cnt : lock_cnt + 1'b1;
        rl_n    = same ? ((run_len == RL_MAX) ? run_len : run_len + 1'b1)
                       : (pos | neg) ? RL_W'(1) : run_len;
        run_hit = same & (rl_n == RL_MAX);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt  <= '0;
            run_len   <= '0;
            last_sign <= 1'b0;
            lock      <= 1'b0;
        end else begin
            lock <= (st_n == TRACK);
            if (pgm) begin
                lock_cnt  <= '0;
                run_len   <= '0;
                last_sign <= 1'b0;
            end else if (st != HOLD) begin
                lock_cnt  <= lc_n;
                run_len   <= rl_n;
                last_sign <= (pos | neg) ? neg : last_sign;
            end
        end
    end
`else
    assign lock = 1'b0;
`endif
    always_comb begin
        st_n = st;
        if (pgm) st_n = HOLD;
        else if (st == HOLD) st_n = ACQUIRE;
`ifdef ADPLL_LOCK_DETECT_EN
        else if (st == ACQUIRE && lc_n == LC_MAX) st_n = TRACK;
        else if (st == TRACK && run_hit) st_n = ACQUIRE;
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= HOLD;
        else st <= st_n;
    end
endmodule
